// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the issue stage and the execution ALU.
// master drives requests and accepts results; slave is the ALU side.
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      outsel;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    modport master (
        output in_valid, outsel, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, outsel, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execution ALU: 1-cycle logic/arith/compare, 1+ceil(shamt/SHIFT_PER_CYCLE) for SLL/SRA.
// One op in flight; in_ready low until the result is taken, result held while out_ready is low.
module alu_exec_unit #(
    parameter int XLEN            = 32,
    parameter int SHAMT_W         = 5,
    parameter int SHIFT_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    alu_exec_unit_if.slave  bus
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_XOR  = 4'b1100;

    localparam logic [SHAMT_W:0] SPC_W = (SHAMT_W + 1)'(SHIFT_PER_CYCLE);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state_q, state_d;
    logic [XLEN-1:0]     work_q, work_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic                sra_q, sra_d;
    logic                zero_q, zero_d;
    logic                illegal_q, illegal_d;

    logic [XLEN-1:0]        alu_res;
    logic                   alu_ill;
    logic                   is_shift;
    logic [SHAMT_W-1:0]     shamt;
    logic [SHAMT_W:0]       step;
    logic signed [XLEN-1:0] sra_val;
    logic [XLEN-1:0]        sll_val;
    logic [XLEN-1:0]        shifted;

    assign shamt    = bus.op_b[SHAMT_W-1:0];
    assign is_shift = (bus.outsel == OP_SLL) || (bus.outsel == OP_SRA);

    // Single-cycle result; a zero-distance shift simply passes op_a through.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (bus.outsel)
            OP_AND:  alu_res = bus.op_a & bus.op_b;
            OP_OR:   alu_res = bus.op_a | bus.op_b;
            OP_XOR:  alu_res = bus.op_a ^ bus.op_b;
            OP_ADD:  alu_res = bus.op_a + bus.op_b;
            OP_SUB:  alu_res = bus.op_a - bus.op_b;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (bus.op_a < bus.op_b)};
            OP_SLL,
            OP_SRA:  alu_res = bus.op_a;
            default: alu_ill = 1'b1;
        endcase
    end

    // Per-cycle shift distance is capped by the remaining count.
    always_comb begin
        step    = ({1'b0, cnt_q} < SPC_W) ? {1'b0, cnt_q} : SPC_W;
        sra_val = $signed(work_q) >>> step;
        sll_val = work_q << step;
        shifted = sra_q ? sra_val : sll_val;
    end

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        sra_d     = sra_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (is_shift && (shamt != '0)) begin
                        state_d = SHIFT;
                        work_d  = bus.op_a;
                        cnt_d   = shamt;
                        sra_d   = (bus.outsel == OP_SRA);
                    end else begin
                        state_d   = DONE;
                        result_d  = alu_res;
                        zero_d    = (alu_res == '0);
                        illegal_d = alu_ill;
                    end
                end
            end
            SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q - step[SHAMT_W-1:0];
                if (cnt_q == step[SHAMT_W-1:0]) begin
                    state_d   = DONE;
                    result_d  = shifted;
                    zero_d    = (shifted == '0);
                    illegal_d = 1'b0;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            work_q    <= '0;
            cnt_q     <= '0;
            sra_q     <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            sra_q     <= sra_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed plus randomized bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;
    localparam int XLEN = 32;
    localparam int SPC  = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_exec_unit_if #(.XLEN(XLEN)) bus ();

    alu_exec_unit #(.XLEN(XLEN), .SHAMT_W(5), .SHIFT_PER_CYCLE(SPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: result, illegal flag and accept-to-valid latency straight from the op definitions.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
        int sh;
        sh  = int'(b[4:0]);
        r   = 32'h0;
        ill = 1'b0;
        lat = 1;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: r = (a < b) ? 32'd1 : 32'd0;
            4'b1001: begin r = a << sh; lat = 1 + (sh + SPC - 1) / SPC; end
            4'b1011: begin r = $signed(a) >>> sh; lat = 1 + (sh + SPC - 1) / SPC; end
            4'b1100: r = a ^ b;
            default: ill = 1'b1;
        endcase
    endfunction

    // Called at a negedge with the unit idle; returns at a negedge with the unit idle again.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        logic [31:0] er;
        logic        eill;
        int          elat;
        int          lat;
        bit          seen;
        bit          busy_bad;
        bit          hold_bad;
        logic [31:0] held;
        model(op, a, b, er, eill, elat);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.outsel   = op;
        bus.op_a     = a;
        bus.op_b     = b;
        lat      = 0;
        seen     = 1'b0;
        busy_bad = 1'b0;
        @(posedge clk);
        while (!seen && lat < 200) begin
            #1;
            // Garbage on the request side must not disturb the op in flight.
            bus.in_valid = 1'($urandom);
            bus.outsel   = 4'($urandom);
            bus.op_a     = $urandom;
            bus.op_b     = $urandom;
            @(negedge clk);
            lat++;
            if (bus.out_valid === 1'b1) seen = 1'b1;
            if (bus.in_ready !== 1'b0) busy_bad = 1'b1;
        end
        check({tag, "_latency"}, 32'(lat), 32'(elat));
        check({tag, "_busy"}, 32'(busy_bad), 32'd0);
        check({tag, "_result"}, bus.result, er);
        check({tag, "_zero"}, 32'(bus.zero), 32'(er == 32'h0));
        check({tag, "_illegal"}, 32'(bus.illegal), 32'(eill));
        held     = bus.result;
        hold_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'($urandom);
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== held) hold_bad = 1'b1;
        end
        if (hold > 0) check({tag, "_hold"}, 32'(hold_bad), 32'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_back_idle"}, {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
        bus.out_ready = 1'b0;
    endtask

    initial begin : stim
        logic [3:0] ops [12];
        bit         aborted_bad;
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000,
                4'b1001, 4'b1011, 4'b1100, 4'b1111, 4'b0101, 4'b0011};
        bus.in_valid  = 1'b0;
        bus.outsel    = 4'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", bus.result, 32'h0);
        check("rst_zero", 32'(bus.zero), 32'd1);
        check("rst_illegal", 32'(bus.illegal), 32'd0);

        // out_ready with nothing pending is inert
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ordy", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
        bus.out_ready = 1'b0;

        run_op("add_wrap", 4'b0010, 32'h7FFF_FFFF, 32'h1, 0);
        check("add_wrap_val", bus.result, 32'h8000_0000);
        run_op("sub_zero", 4'b0110, 32'd5, 32'd5, 0);
        check("sub_zero_flag", 32'(bus.zero), 32'd1);
        run_op("slt", 4'b0111, 32'hFFFF_FFFF, 32'h1, 0);
        check("slt_val", bus.result, 32'h1);
        run_op("sltu", 4'b1000, 32'hFFFF_FFFF, 32'h1, 0);
        run_op("xor", 4'b1100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);
        check("xor_val", bus.result, 32'hFF00_FF00);
        run_op("or", 4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);
        check("or_val", bus.result, 32'hFFF0_FFF0);
        run_op("and", 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);
        check("and_val", bus.result, 32'h00F0_00F0);
        run_op("sra31", 4'b1011, 32'h8000_0000, 32'd31, 0);
        check("sra31_val", bus.result, 32'hFFFF_FFFF);
        run_op("sll0", 4'b1001, 32'h1, 32'd0, 0);
        run_op("sll4", 4'b1001, 32'h3, 32'd4, 0);
        check("sll4_val", bus.result, 32'h30);
        run_op("add_bp", 4'b0010, 32'd100, 32'd23, 10);
        run_op("ill_none", 4'b1111, 32'h1234, 32'h5678, 0);
        run_op("ill_0101", 4'b0101, 32'h1234, 32'h5678, 0);
        run_op("add_after_ill", 4'b0010, 32'd1, 32'd1, 0);
        check("add_after_ill_flag", 32'(bus.illegal), 32'd0);

        // Reset in the middle of a long SRA
        bus.in_valid = 1'b1;
        bus.outsel   = 4'b1011;
        bus.op_a     = 32'h8000_0000;
        bus.op_b     = 32'd31;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_shift_busy", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_result", bus.result, 32'h0);
        check("abort_zero", 32'(bus.zero), 32'd1);
        aborted_bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) aborted_bad = 1'b1;
        end
        check("abort_no_valid", 32'(aborted_bad), 32'd0);
        run_op("add_post_rst", 4'b0010, 32'd2, 32'd3, 0);
        check("add_post_rst_val", bus.result, 32'd5);

        for (int n = 0; n < 40; n++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = ops[$urandom_range(11, 0)];
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(3, 0) == 0) b = a;
            run_op($sformatf("rnd%0d_op%0h", n, op), op, a, b, int'($urandom_range(3, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
